// File: rtl/brake_light_ctrl.sv
// Brake / turn / hazard lamp controller with brake peak-hold and dim power indicator.
// All outputs are registered; next-state logic is a single combinational block.
module brake_light_ctrl #(
    parameter int LAMPS       = 3,
    parameter int PWM_BITS    = 6,
    parameter int DIM_DUTY    = 1,
    parameter int BLINK_DIV   = 1000000,
    parameter int HOLD_CYCLES = 500000
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             pwr,
    input  logic [1:0]       brake_intensity,
    input  logic             brake_valid,
    input  logic             turn_left,
    input  logic             turn_right,
    output logic [LAMPS-1:0] lamp_left,
    output logic [LAMPS-1:0] lamp_right,
    output logic             lamp_middle,
    output logic [2:0]       mode
);

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        IDLE   = 3'd1,
        BRAKE  = 3'd2,
        TURN_L = 3'd3,
        TURN_R = 3'd4,
        HAZARD = 3'd5
    } state_t;

    localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int HALF = (LAMPS + 1) / 2;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [31:0] DUTY = 32'(DIM_DUTY);

    state_t            state_q, state_d;
    logic [1:0]        req_q, req_d;
    logic [1:0]        disp_q, disp_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [BW-1:0]     presc_q, presc_d;
    logic              phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [LAMPS-1:0]  left_q, left_d;
    logic [LAMPS-1:0]  right_q, right_d;
    logic              mid_q, mid_d;
    logic [LAMPS-1:0]  mask;
    logic [LAMPS-1:0]  flash;
    logic              dim_on;

    function automatic logic [LAMPS-1:0] lvl_mask(input logic [1:0] lvl);
        logic [LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < LAMPS; i++) begin
            m[i] = (lvl == 2'd3) ||
                   (lvl == 2'd2 && i < HALF) ||
                   (lvl == 2'd1 && i == 0);
        end
        return m;
    endfunction

    function automatic logic is_blink(input state_t s);
        return (s == TURN_L) || (s == TURN_R) || (s == HAZARD);
    endfunction

    assign dim_on = ({{(32-PWM_BITS){1'b0}}, pwm_q} < DUTY);

    // Next-state: level capture, peak-hold, mode priority, blink and lamp bars
    always_comb begin
        req_d   = brake_valid ? brake_intensity : req_q;
        disp_d  = disp_q;
        hold_d  = hold_q;
        presc_d = presc_q;
        phase_d = phase_q;
        pwm_d   = pwm_q + 1'b1;
        state_d = OFF;
        if (!pwr) begin
            disp_d  = '0;
            hold_d  = '0;
            presc_d = '0;
            pwm_d   = '0;
        end else begin
            if (req_d >= disp_q) begin
                disp_d = req_d;
                hold_d = HOLD_LD;
            end else if (hold_q == '0) begin
                disp_d = req_d;
            end else begin
                hold_d = hold_q - 1'b1;
            end
            if (turn_left && turn_right) state_d = HAZARD;
            else if (turn_left)          state_d = TURN_L;
            else if (turn_right)         state_d = TURN_R;
            else if (disp_d != 2'd0)     state_d = BRAKE;
            else                         state_d = IDLE;
            if (is_blink(state_d) && !is_blink(state_q)) begin
                presc_d = '0;
                phase_d = 1'b1;
            end else if (presc_q == BLINK_LAST) begin
                presc_d = '0;
                phase_d = ~phase_q;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        mask    = lvl_mask(disp_d);
        flash   = {LAMPS{phase_d}};
        left_d  = '0;
        right_d = '0;
        mid_d   = 1'b0;
        unique case (state_d)
            IDLE:    mid_d = dim_on;
            BRAKE: begin
                left_d  = mask;
                right_d = mask;
            end
            TURN_L: begin
                left_d  = flash;
                right_d = mask;
            end
            TURN_R: begin
                left_d  = mask;
                right_d = flash;
            end
            HAZARD: begin
                left_d  = flash;
                right_d = flash;
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= OFF;
            req_q   <= '0;
            disp_q  <= '0;
            hold_q  <= '0;
            presc_q <= '0;
            phase_q <= 1'b0;
            pwm_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            mid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            disp_q  <= disp_d;
            hold_q  <= hold_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            pwm_q   <= pwm_d;
            left_q  <= left_d;
            right_q <= right_d;
            mid_q   <= mid_d;
        end
    end

    assign lamp_left   = left_q;
    assign lamp_right  = right_q;
    assign lamp_middle = mid_q;
    assign mode        = state_q;

endmodule

// File: tb/tb_brake_light_ctrl.sv
// Self-checking bench for brake_light_ctrl: vector table plus blink/hold/reset sequences.
// Expected {left,right,middle,mode} words are queued on drive and popped after the edge.
module tb_brake_light_ctrl;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       pwr;
    logic [1:0] brake_intensity;
    logic       brake_valid;
    logic       turn_left;
    logic       turn_right;
    logic [2:0] lamp_left;
    logic [2:0] lamp_right;
    logic       lamp_middle;
    logic [2:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] sb_q[$];
    string      nm_q[$];

    typedef struct {
        logic       p;
        logic       v;
        logic [1:0] b;
        logic [2:0] msk;
        logic       mid;
        logic [2:0] md;
    } vec_t;

    vec_t tbl[21];

    brake_light_ctrl #(
        .LAMPS(3), .PWM_BITS(4), .DIM_DUTY(2),
        .BLINK_DIV(4), .HOLD_CYCLES(5)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .pwr(pwr),
        .brake_intensity(brake_intensity),
        .brake_valid(brake_valid),
        .turn_left(turn_left),
        .turn_right(turn_right),
        .lamp_left(lamp_left),
        .lamp_right(lamp_right),
        .lamp_middle(lamp_middle),
        .mode(mode)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic vec_t mk(logic p, logic v, logic [1:0] b,
                                logic [2:0] msk, logic mid, logic [2:0] md);
        vec_t r;
        r.p = p; r.v = v; r.b = b; r.msk = msk; r.mid = mid; r.md = md;
        return r;
    endfunction

    task automatic check(input string nm, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got l=%b r=%b m=%b mode=%0d, want l=%b r=%b m=%b mode=%0d",
                     nm, got[9:7], got[6:4], got[3], got[2:0],
                     exp[9:7], exp[6:4], exp[3], exp[2:0]);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic cyc(input logic p, input logic v, input logic [1:0] b,
                       input logic tl, input logic tr, input logic [9:0] exp,
                       input string nm);
        logic [9:0] e;
        string      n;
        pwr = p; brake_valid = v; brake_intensity = b;
        turn_left = tl; turn_right = tr;
        sb_q.push_back(exp);
        nm_q.push_back(nm);
        @(posedge sys_clk);
        #1;
        e = sb_q.pop_front();
        n = nm_q.pop_front();
        check(n, {lamp_left, lamp_right, lamp_middle, mode}, e);
    endtask

    initial begin
        int ones;
        logic [2:0] ph;
        reset = 1'b1; pwr = 1'b0; brake_intensity = 2'd0;
        brake_valid = 1'b0; turn_left = 1'b0; turn_right = 1'b0;

        tbl[0]  = mk(1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'd0);
        tbl[1]  = mk(1'b1, 1'b1, 2'd1, 3'b001, 1'b0, 3'd2);
        tbl[2]  = mk(1'b1, 1'b1, 2'd2, 3'b011, 1'b0, 3'd2);
        tbl[3]  = mk(1'b1, 1'b1, 2'd3, 3'b111, 1'b0, 3'd2);
        tbl[4]  = mk(1'b1, 1'b0, 2'd2, 3'b111, 1'b0, 3'd2);
        tbl[5]  = mk(1'b1, 1'b1, 2'd0, 3'b111, 1'b0, 3'd2);
        for (int i = 6; i <= 9; i++)
            tbl[i] = mk(1'b1, 1'b0, 2'd0, 3'b111, 1'b0, 3'd2);
        tbl[10] = mk(1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 3'd1);
        tbl[11] = mk(1'b1, 1'b1, 2'd3, 3'b111, 1'b0, 3'd2);
        tbl[12] = mk(1'b1, 1'b1, 2'd0, 3'b111, 1'b0, 3'd2);
        tbl[13] = mk(1'b1, 1'b0, 2'd0, 3'b111, 1'b0, 3'd2);
        tbl[14] = mk(1'b1, 1'b1, 2'd3, 3'b111, 1'b0, 3'd2);
        tbl[15] = mk(1'b1, 1'b1, 2'd0, 3'b111, 1'b0, 3'd2);
        for (int i = 16; i <= 19; i++)
            tbl[i] = mk(1'b1, 1'b0, 2'd0, 3'b111, 1'b0, 3'd2);
        tbl[20] = mk(1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 3'd1);

        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_hold", {lamp_left, lamp_right, lamp_middle, mode}, 10'd0);
        @(negedge sys_clk);
        reset = 1'b0;

        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, "off");

        // Idle dim indicator: on for the first 2 of each 16 counts
        ones = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0,
                {3'b000, 3'b000, ((k % 16) < 2), 3'd1}, $sformatf("idle_%0d", k));
            ones += int'(lamp_middle);
        end
        n_checks++;
        if (ones != 4) begin
            n_fail++;
            $display("FAIL idle_duty: got %0d on-cycles, want 4", ones);
        end

        // Brake levels and peak-hold from the table
        for (int i = 0; i < 21; i++)
            cyc(tbl[i].p, tbl[i].v, tbl[i].b, 1'b0, 1'b0,
                {tbl[i].msk, tbl[i].msk, tbl[i].mid, tbl[i].md},
                $sformatf("vec_%0d", i));

        // Turn over full brake, then hazard added mid-phase, then release
        cyc(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, {3'b111, 3'b111, 1'b0, 3'd2}, "pre_turn");
        for (int k = 0; k < 18; k++) begin
            ph = ((k / 4) % 2 == 0) ? 3'b111 : 3'b000;
            cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, {ph, 3'b111, 1'b0, 3'd3},
                $sformatf("turn_l_%0d", k));
        end
        for (int k = 18; k < 26; k++) begin
            ph = ((k / 4) % 2 == 0) ? 3'b111 : 3'b000;
            cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, {ph, ph, 1'b0, 3'd5},
                $sformatf("hazard_%0d", k));
        end
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, {3'b111, 3'b111, 1'b0, 3'd2}, "drop_turn");
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, {3'b111, 3'b111, 1'b0, 3'd4}, "turn_r");

        // Async reset between edges while blinking
        cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, {3'b111, 3'b111, 1'b0, 3'd3}, "turn_l_entry");
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", {lamp_left, lamp_right, lamp_middle, mode}, 10'd0);
        @(negedge sys_clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, {3'b111, 3'b000, 1'b0, 3'd3}, "post_reset");
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 10'd0, "pwr_off");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/brake_light_ctrl.md
BRAKE_LIGHT_CTRL -- requirements
Module: brake_light_ctrl

Interface
REQ-001 Parameter LAMPS, default 3: lamps per side, range 2..8.
REQ-002 Parameter PWM_BITS, default 6: width of the dim-PWM counter.
REQ-003 Parameter DIM_DUTY, default 1: power-on indicator duty, in counts of 2^PWM_BITS.
REQ-004 Parameter BLINK_DIV, default 1000000: sys_clk cycles per blink half-period, at least 2.
REQ-005 Parameter HOLD_CYCLES, default 500000: brake-release hold time in sys_clk cycles; 0 disables hold.
REQ-006 sys_clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high; release is synchronous to sys_clk.
REQ-008 pwr  in  1  system enable.
REQ-009 brake_intensity  in  2  requested brake level 0..3.
REQ-010 brake_valid  in  1  qualifies brake_intensity; ignored when low.
REQ-011 turn_left  in  1  left turn request.
REQ-012 turn_right  in  1  right turn request.
REQ-013 lamp_left  out  LAMPS  left lamp bar; bit 0 is innermost.
REQ-014 lamp_right  out  LAMPS  right lamp bar; bit 0 is innermost.
REQ-015 lamp_middle  out  1  power indicator.
REQ-016 mode  out  3  current state encoding: OFF=0, IDLE=1, BRAKE=2, TURN_L=3, TURN_R=4, HAZARD=5.

Function
REQ-017 All outputs SHALL be registered, with 1-cycle latency from sampled inputs.
REQ-018 State priority SHALL be evaluated every cycle, in this order:
- pwr=0 -> OFF
- turn_left and turn_right both high -> HAZARD
- turn_left high -> TURN_L
- turn_right high -> TURN_R
- displayed brake level (disp_lvl) nonzero -> BRAKE
- otherwise -> IDLE
REQ-019 OFF SHALL drive all lamps 0 and clear disp_lvl, the hold counter, the blink prescaler and the PWM counter.
REQ-020 A sampled level (req_lvl) SHALL load from brake_intensity only on a cycle with brake_valid=1 and SHALL otherwise retain its value.
REQ-021 Brake level to lamp mask: level 0 -> none; level 1 -> bit 0; level 2 -> bits 0..(LAMPS+1)/2-1; level 3 -> all bits.
REQ-022 Brake peak-hold SHALL operate as follows:
- req_lvl >= disp_lvl: disp_lvl <= req_lvl, and the hold counter loads HOLD_CYCLES.
- req_lvl < disp_lvl: the hold counter decrements; on the cycle it is 0, disp_lvl <= req_lvl.
- Any rise during the countdown reloads the counter.
REQ-023 Blink: the prescaler SHALL count 0..BLINK_DIV-1 and wrap to 0; on the wrap, phase toggles.
REQ-024 On entry to TURN_L, TURN_R or HAZARD from any other state, the prescaler SHALL clear and phase SHALL be set to 1, so the first flash is immediate.
REQ-025 Changing between TURN_L, TURN_R and HAZARD SHALL NOT reset the blink prescaler or phase.
REQ-026 TURN_L: lamp_left SHALL equal {LAMPS{phase}}, and lamp_right SHALL equal the brake mask of disp_lvl.
REQ-027 TURN_R SHALL mirror TURN_L.
REQ-028 HAZARD: both bars SHALL equal {LAMPS{phase}}.
REQ-029 BRAKE: both bars SHALL equal the brake mask of disp_lvl.
REQ-030 IDLE: both bars SHALL be 0.
REQ-031 lamp_middle SHALL be 1 only in IDLE and only when the free-running PWM counter < DIM_DUTY; otherwise 0.
REQ-032 DIM_DUTY=0 SHALL give lamp_middle constant 0, and DIM_DUTY >= 2^PWM_BITS SHALL give constant 1 in IDLE.
REQ-033 The PWM counter SHALL wrap from 2^PWM_BITS-1 to 0 with no skipped count.
REQ-034 Turn requests SHALL NOT alter req_lvl, disp_lvl or the hold countdown, which continue during turns.
REQ-035 HOLD_CYCLES=0 SHALL make a decrease take effect on the cycle after it is sampled.

Reset
REQ-036 While reset is high, the block SHALL hold:
- lamp_left, lamp_right, lamp_middle at 0; mode at OFF
- req_lvl, disp_lvl, the hold counter, the blink prescaler, phase and the PWM counter at 0
REQ-037 Reset asserted mid-blink or mid-hold SHALL abort immediately, with no residual lamp output.
REQ-038 After release with pwr=1, the first registered state SHALL be IDLE, or a higher-priority state if requested.

Verification
Bench parameters: LAMPS=3, PWM_BITS=4, DIM_DUTY=2, BLINK_DIV=4, HOLD_CYCLES=5.
REQ-039 Power-on idle: pwr=1, no requests -> lamp_middle high 2 of every 16 cycles, bars 000, mode=1.
REQ-040 Brake levels: valid pulses with levels 1, 2, 3 in ascending order -> masks 001, 011, 111 one cycle after each pulse; level 2 with brake_valid=0 -> no change.
REQ-041 Peak-hold: from level 3, valid level 0 -> 111 for 5 further cycles, then 000 and mode=1; a valid level 3 at cycle 3 of the countdown reloads the hold.
REQ-042 Turn over brake: disp_lvl=3, assert turn_left -> lamp_left 111 for 4 cycles then 000 for 4, repeating, while lamp_right stays 111; lamp_middle=0.
REQ-043 Hazard and transition: turn_left then turn_right added mid-phase -> both bars blink in phase with no prescaler restart; drop both -> BRAKE mask within 1 cycle.
REQ-044 Async reset: assert reset mid-blink between clock edges -> all outputs 0 before the next edge; pwr=0 at any time -> mode=0 and bars 000 next cycle.
